bus_arbiter: RTL and testbench

Round-robin arbiter and watchdog for the shared system bus used by the bus-master blocks (camera grabber, DMA, CPU data port). Each master raises a request line and receives a one-hot grant. The arbiter holds the grant until the master's end-of-transaction, and aborts stalled masters with a timeout. It also drives the bus-error and end-transaction lines on abort so that slaves and the master return to idle.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/rr_priority_select.sv | 41 ++++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types, constants and helpers for the bus arbiter
// Contents: arbiter state encoding, clog2 helper, default sizing constants.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BEGIN = 2'd1,
    ST_IN_TRANS   = 2'd2,
    ST_ABORT      = 2'd3
  } arb_state_e;

  localparam int DEFAULT_NR_MASTERS     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  // Number of bits needed to hold values 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin winner selection
// Ports:
//   request     in  NR_MASTERS  request vector
//   last_grant  in  ID_W        index of the previous winner
//   grant       out NR_MASTERS  one-hot winner (zero when no request)
//   grant_idx   out ID_W        index of the winner
//   grant_valid out 1           at least one request present
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int NR_MASTERS = DEFAULT_NR_MASTERS,
  parameter int ID_W       = clog2(NR_MASTERS)
) (
  input  logic [NR_MASTERS-1:0] request,
  input  logic [ID_W-1:0]       last_grant,
  output logic [NR_MASTERS-1:0] grant,
  output logic [ID_W-1:0]       grant_idx,
  output logic                  grant_valid
);

  logic [ID_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant is the final (winning) assignment.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = NR_MASTERS; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NR_MASTERS);
      if (request[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with transaction watchdog
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   requestBus            per-master request
//   busGrant              registered one-hot grant
//   beginTransactionIn    OR of masters' begin strobes
//   endTransactionIn      OR of masters' end strobes
//   dataValidIn           OR of masters' data-valid strobes
//   busyIn                slave busy
//   busErrorOut           one-cycle pulse on watchdog abort
//   endTransactionOut     one-cycle pulse on watchdog abort
//   grantedId             index of current or last grant
//   busIdle               arbiter idle
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NR_MASTERS     = DEFAULT_NR_MASTERS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ID_W          = clog2(NR_MASTERS),
  localparam int CNT_W         = clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] requestBus,
  output logic [NR_MASTERS-1:0] busGrant,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  dataValidIn,
  input  logic                  busyIn,
  output logic                  busErrorOut,
  output logic                  endTransactionOut,
  output logic [ID_W-1:0]       grantedId,
  output logic                  busIdle
);

  localparam logic [CNT_W-1:0] WDOG_RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RESET  = ID_W'(NR_MASTERS - 1);

  arb_state_e state, next_state;

  logic [ID_W-1:0]       last_grant;
  logic [CNT_W-1:0]      wdog;
  logic [NR_MASTERS-1:0] sel_grant;
  logic [ID_W-1:0]       sel_idx;
  logic                  sel_valid;
  logic                  timeout;
  logic                  granted_req;

  rr_priority_select #(
    .NR_MASTERS (NR_MASTERS),
    .ID_W       (ID_W)
  ) u_select (
    .request     (requestBus),
    .last_grant  (last_grant),
    .grant       (sel_grant),
    .grant_idx   (sel_idx),
    .grant_valid (sel_valid)
  );

  assign timeout     = (wdog == '0);
  assign granted_req = requestBus[grantedId];
  assign busIdle     = (state == ST_IDLE);

  // Event priority inside each state follows the if/else order:
  // begin > request drop > timeout, and end > timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (sel_valid) next_state = ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        if (beginTransactionIn)  next_state = ST_IN_TRANS;
        else if (!granted_req)   next_state = ST_IDLE;
        else if (timeout)        next_state = ST_ABORT;
      end
      ST_IN_TRANS: begin
        if (endTransactionIn)    next_state = ST_IDLE;
        else if (timeout)        next_state = ST_ABORT;
      end
      ST_ABORT: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      busGrant          <= '0;
      busErrorOut       <= 1'b0;
      endTransactionOut <= 1'b0;
      grantedId         <= '0;
      last_grant        <= LAST_RESET;
      wdog              <= WDOG_RELOAD;
    end else begin
      state             <= next_state;
      busErrorOut       <= (next_state == ST_ABORT);
      endTransactionOut <= (next_state == ST_ABORT);

      if (state == ST_IDLE && next_state == ST_WAIT_BEGIN) begin
        busGrant   <= sel_grant;
        last_grant <= sel_idx;
        grantedId  <= sel_idx;
      end else if (next_state == ST_IDLE || next_state == ST_ABORT) begin
        busGrant <= '0;
      end

      // Any bus activity or state change restarts the watchdog; otherwise
      // it counts down and parks at zero.
      if (next_state != state || dataValidIn || busyIn) begin
        wdog <= WDOG_RELOAD;
      end else if (wdog != '0) begin
        wdog <= wdog - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] requestBus;
  logic [NR-1:0] busGrant;
  logic          beginTransactionIn;
  logic          endTransactionIn;
  logic          dataValidIn;
  logic          busyIn;
  logic          busErrorOut;
  logic          endTransactionOut;
  logic [1:0]    grantedId;
  logic          busIdle;

  logic [4:0]    rr_req;
  logic [2:0]    rr_last;
  logic [4:0]    rr_grant;
  logic [2:0]    rr_idx;
  logic          rr_valid;

  int n_compared   = 0;
  int n_mismatched = 0;
  int abort_cycles = 0;

  logic [NR-1:0] exp_q[$];
  logic [NR-1:0] prev_grant = '0;

  always #5 clock = ~clock;

  bus_arbiter #(
    .NR_MASTERS     (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .requestBus         (requestBus),
    .busGrant           (busGrant),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .dataValidIn        (dataValidIn),
    .busyIn             (busyIn),
    .busErrorOut        (busErrorOut),
    .endTransactionOut  (endTransactionOut),
    .grantedId          (grantedId),
    .busIdle            (busIdle)
  );

  rr_priority_select #(
    .NR_MASTERS (5),
    .ID_W       (3)
  ) u_rr (
    .request     (rr_req),
    .last_grant  (rr_last),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard: every new grant pops the expected one-hot vector.
  always @(negedge clock) begin
    if (!reset) begin
      if (busGrant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          check_value("sb_unexpected_grant", 32'(busGrant), 32'h0);
        end else begin
          check_value("sb_grant", 32'(busGrant), 32'(exp_q.pop_front()));
        end
      end
      if (busErrorOut) abort_cycles++;
    end
    prev_grant = busGrant;
  end

  // Begin, then beats of data with end on the last beat; requests updated with the end.
  task automatic run_trans(input int beats, input logic [NR-1:0] req_after);
    beginTransactionIn = 1'b1;
    tick(1);
    beginTransactionIn = 1'b0;
    for (int b = 0; b < beats; b++) begin
      dataValidIn      = 1'b1;
      endTransactionIn = (b == beats - 1);
      if (b == beats - 1) requestBus = req_after;
      tick(1);
    end
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] order [5];
    int            waited;
    logic          err_seen;
    logic          exp_v;
    logic [2:0]    exp_i;
    logic [4:0]    exp_g;
    int            c;

    reset = 1'b1; requestBus = '0; beginTransactionIn = 1'b0; endTransactionIn = 1'b0;
    dataValidIn = 1'b0; busyIn = 1'b0;
    rr_req = '0; rr_last = '0;
    tick(2);

    check_value("rst_grant", 32'(busGrant), 32'h0);
    check_value("rst_buserr", 32'(busErrorOut), 32'h0);
    check_value("rst_endout", 32'(endTransactionOut), 32'h0);
    check_value("rst_gid", 32'(grantedId), 32'h0);
    check_value("rst_idle", 32'(busIdle), 32'h1);

    // Burst from master 0, then master 2 after one idle cycle.
    reset = 1'b0; requestBus = 4'b0101; exp_q.push_back(4'b0001);
    tick(1);
    check_value("t1_grant0", 32'(busGrant), 32'h1);
    check_value("t1_gid0", 32'(grantedId), 32'h0);
    exp_q.push_back(4'b0100);
    run_trans(8, 4'b0100);
    check_value("t1_release", 32'(busGrant), 32'h0);
    check_value("t1_idle_gap", 32'(busIdle), 32'h1);
    tick(1);
    check_value("t1_grant2", 32'(busGrant), 32'h4);
    check_value("t1_gid2", 32'(grantedId), 32'h2);
    run_trans(1, 4'b0000);
    check_value("t1_release2", 32'(busGrant), 32'h0);

    // Full contention from a fresh reset: order 0,1,2,3,0.
    reset = 1'b1; tick(1); reset = 1'b0;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    requestBus = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(order[i]);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_value($sformatf("t2_rr_order%0d", i), 32'(busGrant), 32'(order[i]));
      run_trans(1, (i == 4) ? 4'b0000 : 4'b1111);
    end

    // Master 1 granted, never begins: abort after TO cycles.
    requestBus = 4'b0010; exp_q.push_back(4'b0010);
    tick(1);
    check_value("t3_grant1", 32'(busGrant), 32'h2);
    waited = 0;
    while (!busErrorOut && waited < 40) begin
      tick(1);
      waited++;
    end
    check_value("t3_abort_latency", 32'(waited), 32'(TO));
    check_value("t3_buserr", 32'(busErrorOut), 32'h1);
    check_value("t3_endout", 32'(endTransactionOut), 32'h1);
    check_value("t3_grant_clear", 32'(busGrant), 32'h0);
    check_value("t3_not_idle", 32'(busIdle), 32'h0);
    requestBus = 4'b0000;
    tick(1);
    check_value("t3_buserr_end", 32'(busErrorOut), 32'h0);
    check_value("t3_endout_end", 32'(endTransactionOut), 32'h0);
    check_value("t3_idle_back", 32'(busIdle), 32'h1);

    // Busy slave holds off the watchdog.
    requestBus = 4'b0001; exp_q.push_back(4'b0001);
    tick(1);
    check_value("t4_grant0", 32'(busGrant), 32'h1);
    beginTransactionIn = 1'b1; tick(1); beginTransactionIn = 1'b0;
    busyIn = 1'b1; err_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busErrorOut) err_seen = 1'b1;
    end
    check_value("t4_no_abort", 32'(err_seen), 32'h0);
    check_value("t4_still_granted", 32'(busGrant), 32'h1);
    busyIn = 1'b0; endTransactionIn = 1'b1; requestBus = 4'b0000;
    tick(1);
    endTransactionIn = 1'b0;
    check_value("t4_release", 32'(busGrant), 32'h0);

    // End coincides with the watchdog reaching zero: normal release.
    requestBus = 4'b0100; exp_q.push_back(4'b0100);
    tick(1);
    check_value("t5_grant2", 32'(busGrant), 32'h4);
    beginTransactionIn = 1'b1; tick(1); beginTransactionIn = 1'b0;
    tick(TO - 1);
    check_value("t5_pre_end_grant", 32'(busGrant), 32'h4);
    endTransactionIn = 1'b1; requestBus = 4'b0000;
    tick(1);
    endTransactionIn = 1'b0;
    check_value("t5_no_buserr", 32'(busErrorOut), 32'h0);
    check_value("t5_no_endout", 32'(endTransactionOut), 32'h0);
    check_value("t5_release", 32'(busGrant), 32'h0);
    check_value("t5_idle", 32'(busIdle), 32'h1);

    // Reset mid-burst while master 2 holds the bus.
    requestBus = 4'b0100; exp_q.push_back(4'b0100);
    tick(1);
    check_value("t6_grant2", 32'(busGrant), 32'h4);
    beginTransactionIn = 1'b1; tick(1); beginTransactionIn = 1'b0;
    dataValidIn = 1'b1; tick(3);
    reset = 1'b1;
    tick(1);
    dataValidIn = 1'b0;
    check_value("t6_rst_grant", 32'(busGrant), 32'h0);
    check_value("t6_rst_endout", 32'(endTransactionOut), 32'h0);
    check_value("t6_rst_idle", 32'(busIdle), 32'h1);
    reset = 1'b0; requestBus = 4'b1101; exp_q.push_back(4'b0001);
    tick(1);
    check_value("t6_first_after_rst", 32'(busGrant), 32'h1);
    run_trans(1, 4'b0000);

    // Standalone selector against a cyclic-search model with 5 requesters.
    for (int t = 0; t < 40; t++) begin
      rr_req  = (t == 0) ? 5'b00000 : (t == 1) ? 5'b00100 : 5'($urandom_range(0, 31));
      rr_last = (t == 1) ? 3'd2 : 3'($urandom_range(0, 4));
      #1;
      exp_v = 1'b0; exp_i = '0; exp_g = '0;
      for (int s = 1; s <= 5; s++) begin
        c = (int'(rr_last) + s) % 5;
        if (rr_req[c] && !exp_v) begin
          exp_v = 1'b1;
          exp_i = 3'(c);
          exp_g = 5'(1 << c);
        end
      end
      check_value($sformatf("rr_sel%0d", t), 32'({rr_valid, rr_idx, rr_grant}), 32'({exp_v, exp_i, exp_g}));
    end

    tick(2);
    check_value("abort_pulse_total", 32'(abort_cycles), 32'h1);
    check_value("sb_leftover", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
